// File: rtl/param_accum_alu_pkg.sv
// param_accum_alu_pkg
// Shared types and arithmetic for the parametrised accumulate/ALU unit.
//   mode_t    : operation select (ADD, SUB, ACC, SAT)
//   alu_calc  : computes {carry,result} for a run-time width w (2..16).
//               The result sits in bits [w-1:0] and the flag in bit w of
//               the 17-bit return value; bits above w are always zero.
package param_accum_alu_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_SAT = 2'b11
    } mode_t;

    localparam int MAX_W = 16;

    // acc is the accumulator value already adjusted for a same-cycle clear.
    function automatic logic [16:0] alu_calc(
        input mode_t       m,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] acc,
        input logic [4:0]  w
    );
        logic [16:0] mask;
        logic [16:0] sum;
        logic [16:0] out;
        mask = (17'd1 << w) - 17'd1;
        sum  = 17'd0;
        out  = 17'd0;
        case (m)
            MODE_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                out    = sum & mask;
                out[w] = sum[w];
            end
            MODE_SUB: begin
                // Low w bits of the 17-bit difference are the modular result;
                // the flag is a plain magnitude compare (borrow).
                sum    = {1'b0, a} - {1'b0, b};
                out    = sum & mask;
                out[w] = (a < b);
            end
            MODE_ACC: begin
                sum    = {1'b0, acc} + {1'b0, a};
                out    = sum & mask;
                out[w] = sum[w];
            end
            MODE_SAT: begin
                sum = {1'b0, a} + {1'b0, b};
                if (sum > mask) begin
                    out = mask | (17'd1 << w);
                end else begin
                    out = sum;
                end
            end
            default: out = 17'd0;
        endcase
        return out;
    endfunction

endpackage

// File: rtl/accum_result_fifo.sv
// accum_result_fifo
// Synchronous DEPTH x DW FIFO with valid/ready on both sides.
//   clk, reset            : clock, asynchronous active-high reset
//   push_valid_i/ready_o  : write handshake, push_data_i payload
//   pop_valid_o/ready_i   : read handshake, pop_data_o shows the head (0 when empty)
// push_ready_o is simply !full: a pop in the same cycle does not open a slot
// for a push, which keeps the ready path free of the consumer's ready.
module accum_result_fifo
    import param_accum_alu_pkg::*;
#(
    parameter int DW    = 5,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_valid_i,
    output logic          push_ready_o,
    input  logic [DW-1:0] push_data_i,
    output logic          pop_valid_o,
    input  logic          pop_ready_i,
    output logic [DW-1:0] pop_data_o
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          full_s, empty_s, push_s, pop_s;

    assign empty_s      = (wr_q == rd_q);
    assign full_s       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign push_s       = push_valid_i && !full_s;
    assign pop_s        = pop_ready_i && !empty_s;
    assign push_ready_o = !full_s;
    assign pop_valid_o  = !empty_s;
    assign pop_data_o   = empty_s ? {DW{1'b0}} : mem_q[rd_q[AW-1:0]];

    // Next-state pointers.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_s) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_d = rd_q;
        end
    end

    // Pointer registers; reset empties the FIFO immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= {(AW+1){1'b0}};
            rd_q <= {(AW+1){1'b0}};
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents are only visible through the empty-gated head.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/param_accum_alu.sv
// param_accum_alu
// W-bit arithmetic unit (ADD/SUB/ACC/SAT) with a result FIFO.
//   clk, reset         : clock, asynchronous active-high reset
//   in_valid/in_ready  : operand handshake; op_a, op_b, mode, sampled on accept
//   acc_clr            : synchronous clear of accumulator and sticky flag
//   out_valid/out_ready: result handshake; result/carry show the FIFO head
//   ovf_sticky         : set by any accepted op whose flag is 1
//   acc                : current accumulator value
module param_accum_alu
    import param_accum_alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [1:0]   mode,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         ovf_sticky,
    output logic [W-1:0] acc
);
    logic [W-1:0] acc_q, acc_d;
    logic         ovf_q, ovf_d;
    logic         accept_s;
    mode_t        mode_s;
    logic [15:0]  acc_base_s;
    logic [16:0]  alu_s;
    logic [W-1:0] res_s;
    logic         carry_s;
    logic [W:0]   head_s;

    assign mode_s   = mode_t'(mode);
    assign accept_s = in_valid && in_ready;

    // A same-cycle clear makes an ACC start from zero.
    assign acc_base_s = acc_clr ? 16'd0 : 16'(acc_q);
    assign alu_s      = alu_calc(mode_s, 16'(op_a), 16'(op_b), acc_base_s, 5'(W));
    assign res_s      = alu_s[W-1:0];
    assign carry_s    = alu_s[W];

    if (W < MAX_W) begin : g_hi
        logic unused_hi_s;
        assign unused_hi_s = ^alu_s[16:W+1];
    end

    // Accumulator and sticky next state: an accepted flag beats a clear.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (accept_s && (mode_s == MODE_ACC)) begin
            acc_d = res_s;
        end else if (acc_clr) begin
            acc_d = {W{1'b0}};
        end else begin
            acc_d = acc_q;
        end
        if (accept_s && carry_s) begin
            ovf_d = 1'b1;
        end else if (acc_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Accumulator and sticky flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= {W{1'b0}};
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    accum_result_fifo #(
        .DW    (W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_valid_i (in_valid),
        .push_ready_o (in_ready),
        .push_data_i  ({carry_s, res_s}),
        .pop_valid_o  (out_valid),
        .pop_ready_i  (out_ready),
        .pop_data_o   (head_s)
    );

    assign result     = head_s[W-1:0];
    assign carry      = head_s[W];
    assign acc        = acc_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_param_accum_alu.sv
module tb_param_accum_alu;
    localparam int W     = 4;
    localparam int DEPTH = 2;
    localparam int MAXV  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [1:0]   mode = 2'b00;
    logic         acc_clr = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry;
    logic         ovf_sticky;
    logic [W-1:0] acc;

    always #5 clk = ~clk;

    param_accum_alu #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .mode       (mode),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carry      (carry),
        .ovf_sticky (ovf_sticky),
        .acc        (acc)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: queued entries are carry*2^W + result.
    int q[$];
    int acc_m = 0;
    int stk_m = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference arithmetic straight from the mode definitions.
    function automatic int model_op(input int m, input int a, input int b, input bit clr);
        int s;
        int base;
        base = clr ? 0 : acc_m;
        case (m)
            0: s = a + b;
            1: return ((a < b) ? (MAXV + 1) : 0) + ((a - b + MAXV + 1) % (MAXV + 1));
            2: s = base + a;
            default: begin
                s = a + b;
                return (s > MAXV) ? (MAXV + 1 + MAXV) : s;
            end
        endcase
        return ((s > MAXV) ? (MAXV + 1) : 0) + (s % (MAXV + 1));
    endfunction

    task automatic check_outputs();
        int head;
        head = (q.size() > 0) ? q[0] : 0;
        check_val("in_ready",   int'(in_ready),   int'(q.size() < DEPTH));
        check_val("out_valid",  int'(out_valid),  int'(q.size() > 0));
        check_val("result",     int'(result),     head % (MAXV + 1));
        check_val("carry",      int'(carry),      head / (MAXV + 1));
        check_val("acc",        int'(acc),        acc_m);
        check_val("ovf_sticky", int'(ovf_sticky), stk_m);
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic step(input bit v, input int a, input int b, input int m,
                        input bit clr, input bit ordy);
        bit acc_ok;
        bit pop;
        int r;
        in_valid  = v;
        op_a      = W'(a);
        op_b      = W'(b);
        mode      = 2'(m);
        acc_clr   = clr;
        out_ready = ordy;
        #1;
        check_outputs();
        acc_ok = v && (q.size() < DEPTH);
        pop    = ordy && (q.size() > 0);
        r      = model_op(m, a, b, clr);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc_ok) q.push_back(r);
        if (acc_ok && (r > MAXV)) stk_m = 1;
        else if (clr) stk_m = 0;
        if (acc_ok && (m == 2)) acc_m = r % (MAXV + 1);
        else if (clr) acc_m = 0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        bit hv;
        int ha, hb, hm;
        bit hold;

        // Reset state
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // Directed arithmetic
        step(1'b1, 9, 8, 0, 1'b0, 1'b1);
        check_val("add_9_8_res", int'(result), 1);
        check_val("add_9_8_c", int'(carry), 1);
        check_val("add_9_8_stk", int'(ovf_sticky), 1);
        step(1'b1, 2, 3, 0, 1'b0, 1'b1);
        check_val("add_2_3_res", int'(result), 5);
        check_val("add_2_3_c", int'(carry), 0);
        step(1'b1, 3, 5, 1, 1'b0, 1'b1);
        check_val("sub_3_5", {27'd0, carry, result}, 16 + 14);
        step(1'b1, 12, 6, 3, 1'b0, 1'b1);
        check_val("sat_c_6", {27'd0, carry, result}, 16 + 15);
        step(1'b1, 4, 3, 3, 1'b0, 1'b1);
        check_val("sat_4_3", {27'd0, carry, result}, 7);

        // Accumulate
        step(1'b0, 0, 0, 0, 1'b1, 1'b1);
        step(1'b1, 7, 0, 2, 1'b0, 1'b1);
        check_val("acc1", {27'd0, carry, result}, 7);
        step(1'b1, 7, 0, 2, 1'b0, 1'b1);
        check_val("acc2", {27'd0, carry, result}, 14);
        step(1'b1, 7, 0, 2, 1'b0, 1'b1);
        check_val("acc3", {27'd0, carry, result}, 16 + 5);
        check_val("acc3_val", int'(acc), 5);
        step(1'b1, 2, 0, 2, 1'b1, 1'b1);
        check_val("accclr_res", int'(result), 2);
        check_val("accclr_acc", int'(acc), 2);
        check_val("accclr_stk", int'(ovf_sticky), 0);
        idle(2);

        // Backpressure: third op held until one cycle after the first pop
        step(1'b1, 1, 1, 0, 1'b0, 1'b0);
        step(1'b1, 2, 2, 0, 1'b0, 1'b0);
        check_val("bp_full", int'(in_ready), 0);
        step(1'b1, 3, 3, 0, 1'b0, 1'b0);
        step(1'b1, 3, 3, 0, 1'b0, 1'b1);
        check_val("bp_after_pop", int'(in_ready), 1);
        step(1'b1, 3, 3, 0, 1'b0, 1'b1);
        idle(3);

        // Reset with two entries queued and acc = 9
        step(1'b1, 9, 0, 2, 1'b1, 1'b0);
        step(1'b1, 1, 1, 0, 1'b0, 1'b0);
        check_val("pre_rst_acc", int'(acc), 9);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_acc", int'(acc), 0);
        check_val("rst_stk", int'(ovf_sticky), 0);
        check_val("rst_result", int'(result), 0);
        q.delete();
        acc_m = 0;
        stk_m = 0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 9, 8, 0, 1'b0, 1'b1);
        check_val("cold_res", {27'd0, carry, result}, 16 + 1);

        // Randomized traffic; a stalled source keeps its operands
        hold = 1'b0;
        hv = 1'b0; ha = 0; hb = 0; hm = 0;
        for (int i = 0; i < 400; i++) begin
            bit clr;
            bit ordy;
            if (!hold) begin
                hv = ($urandom_range(0, 3) != 0);
                ha = int'($urandom_range(0, MAXV));
                hb = int'($urandom_range(0, MAXV));
                hm = int'($urandom_range(0, 3));
            end
            clr  = ($urandom_range(0, 9) == 0);
            ordy = ($urandom_range(0, 2) != 0);
            hold = hv && (q.size() >= DEPTH);
            step(hv, ha, hb, hm, clr, ordy);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/param_accum_alu.md
Name: param_accum_alu

Overview:
- Parametrised successor to the team's nibble adder: a W-bit arithmetic unit with four modes (add, subtract, accumulate, saturating add).
- Operands enter over a valid/ready handshake. Results plus a carry flag are buffered in a DEPTH-entry output FIFO with its own valid/ready handshake.
- Sits between the pad-level input decode and the output mux of the top-level tile.

Parameters:
- W, 4, operand/result width in bits (2..16)
- DEPTH, 2, output FIFO entries; power of two, 2..8

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand transfer request
- in_ready  out  1  unit can accept an operand this cycle
- op_a  in  W  operand A
- op_b  in  W  operand B (ignored in ACC mode)
- mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 SAT; sampled with the operands
- acc_clr  in  1  synchronous accumulator and sticky-flag clear
- out_valid  out  1  FIFO head holds a result
- out_ready  in  1  consumer takes the head this cycle
- result  out  W  FIFO head result
- carry  out  1  FIFO head carry/borrow/saturation flag
- ovf_sticky  out  1  set by any accepted op with carry=1
- acc  out  W  current accumulator value

Behaviour:
- Reset (asynchronous, active-high on reset) forces:
  - FIFO empty: out_valid=0, in_ready=1
  - result=0, carry=0, acc=0, ovf_sticky=0
- Accept happens when in_valid && in_ready.
  - The result is computed combinationally from the sampled inputs and written to the FIFO on that clk edge.
  - out_valid rises the next cycle if the FIFO was empty, giving 1-cycle latency.
- Pop happens when out_valid && out_ready. result and carry always show the FIFO head; their value when empty is 0.
- in_ready = !full. There is no pass-through when full: a pop in the same cycle does not raise in_ready.
- Simultaneous push and pop when not full: occupancy is unchanged and order is preserved.
- Arithmetic, all modulo 2^W with a W+1-bit internal sum:
  - ADD: result=a+b; carry=bit W of the sum.
  - SUB: result=a-b; carry=1 iff a<b (borrow).
  - ACC: acc_next=acc+a; result=acc_next; carry=bit W of the sum; acc is updated on accept only.
  - SAT: result=min(a+b, 2^W-1); carry=1 iff the sum exceeded 2^W-1.
- acc_clr:
  - Alone, it sets acc and ovf_sticky to 0 next cycle.
  - In the same cycle as an ACC accept, clear applies first: acc_next=a, result=a, carry=0.
  - In the same cycle as any accept with carry=1, ovf_sticky ends at 1 (set wins over clear).
  - acc_clr does not affect FIFO contents.
- Non-ACC modes never modify acc.
- in_valid while in_ready=0 has no effect. The source holds its data (standard valid/ready rules).
- Reset mid-operation discards all FIFO entries immediately. In-flight results are lost.

Decomposition:
- Package param_accum_alu_pkg holds:
  - mode_t enum: MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ACC=2'b10, MODE_SAT=2'b11
  - a function computing {carry,result} from mode, a, b and acc, parametrised by W
- One sub-module, accum_result_fifo:
  - synchronous DEPTH x (W+1) FIFO with valid/ready on both sides and asynchronous reset
  - pointers $clog2(DEPTH) bits plus one wrap bit for full/empty detection
- The top module holds the accumulator, the sticky flag and the arithmetic.

Test Plan (W=4, DEPTH=2 unless noted):
- ADD a=0x9, b=0x8, out_ready=1 -> next cycle result=0x1, carry=1, ovf_sticky=1; then ADD 0x2+0x3 -> result=0x5, carry=0.
- SUB a=0x3, b=0x5 -> result=0xE, carry=1. SAT a=0xC, b=0x6 -> result=0xF, carry=1. SAT 0x4+0x3 -> result=0x7, carry=0.
- acc_clr pulse, then three ACC accepts with a=0x7 -> results 0x7, 0xE, 0x5, carry only on the third, final acc=0x5. Then acc_clr with ACC a=0x2 in the same cycle -> result=0x2, acc=0x2, ovf_sticky=0.
- Backpressure: out_ready=0, three back-to-back ADD accepts attempted -> in_ready drops after the second, the third is held. Release out_ready -> results pop in order, the third is accepted one cycle after the first pop.
- Push and pop in the same cycle at occupancy 1 -> occupancy stays 1, out_valid stays 1, order correct.
- Assert reset while the FIFO holds 2 entries and acc=0x9 -> immediately out_valid=0, in_ready=1, acc=0, ovf_sticky=0. First op after release behaves as from cold start.
